// File: rtl/data_mem_resp.sv
// Data memory responder: one outstanding load/store, WAIT_CYCLES wait states, one-cycle response.
// Optional macro DMEM_BYTE_SEL_EN enables byte-lane masked stores; otherwise stores write all 32 bits.

`ifndef RstEnable
`define RstEnable 1'b1
`endif
`ifndef RegBus
`define RegBus 31:0
`endif
`ifndef ZeroWord
`define ZeroWord 32'h0000_0000
`endif

module data_mem_resp #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid_i,
  output logic           req_ready_o,
  input  logic           req_we_i,
  input  logic [`RegBus] req_addr_i,
  input  logic [3:0]     req_sel_i,
  input  logic [`RegBus] req_wdata_i,
  output logic           rsp_valid_o,
  output logic [`RegBus] rsp_rdata_o
);

  localparam int unsigned Words    = 2 ** DEPTH_LOG2;
  localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);
  localparam bit          NoWait   = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                  r_state, w_state_next;
  logic [3:0]              r_cnt, w_cnt_next;
  logic                    r_we;
  logic [DEPTH_LOG2-1:0]   r_idx;
  logic [3:0]              r_sel;
  logic [31:0]             r_wdata;
  logic [31:0]             r_rdata;
  logic [31:0]             r_mem [Words];

  logic                    w_accept;
  logic                    w_enter_resp;
  logic                    w_we;
  logic [DEPTH_LOG2-1:0]   w_idx;
  logic [3:0]              w_sel;
  logic [31:0]             w_wdata;
  logic [31:0]             w_old;
  logic [31:0]             w_merged;
  logic                    w_unused;

  assign w_accept     = req_valid_i && (r_state == StIdle);
  assign w_enter_resp = (w_state_next == StResp) && (r_state != StResp);

  // With zero wait states RESP is entered on the accept edge, before the latches hold the request.
  assign w_we    = (r_state == StIdle) ? req_we_i                      : r_we;
  assign w_idx   = (r_state == StIdle) ? req_addr_i[DEPTH_LOG2+1:2]    : r_idx;
  assign w_sel   = (r_state == StIdle) ? req_sel_i                     : r_sel;
  assign w_wdata = (r_state == StIdle) ? req_wdata_i                   : r_wdata;
  assign w_old   = r_mem[w_idx];

  // Keeps ignored address bits and (in full-word mode) the lane enables lint-visible.
  assign w_unused = ^{req_addr_i, w_sel};

  always_ff @(posedge clk or posedge rst) begin
    if (rst == `RstEnable) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (NoWait) begin
            w_state_next = StResp;
          end else begin
            w_state_next = StWait;
            w_cnt_next   = WaitInit;
          end
        end
      end
      StWait: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_next = StResp;
      end
      StResp:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    req_ready_o = (r_state == StIdle);
    rsp_valid_o = (r_state == StResp);
    rsp_rdata_o = r_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == `RstEnable) begin
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_sel   <= 4'd0;
      r_wdata <= `ZeroWord;
    end else if (w_accept) begin
      r_we    <= req_we_i;
      r_idx   <= req_addr_i[DEPTH_LOG2+1:2];
      r_sel   <= req_sel_i;
      r_wdata <= req_wdata_i;
    end
  end

`ifdef DMEM_BYTE_SEL_EN
  always_comb begin
    w_merged = w_old;
    for (int i = 0; i < 4; i++) begin
      if (w_sel[i]) w_merged[8*i +: 8] = w_wdata[8*i +: 8];
    end
  end
`else
  always_comb begin
    w_merged = w_wdata;
  end
`endif

  // Array is never reset; the rst guard drops a store caught by reset on its commit edge.
  always_ff @(posedge clk) begin
    if (w_enter_resp && w_we && (rst != `RstEnable)) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == `RstEnable) begin
      r_rdata <= `ZeroWord;
    end else if (w_enter_resp) begin
      r_rdata <= w_we ? `ZeroWord : w_old;
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: default-wait instance plus a zero-wait instance.
// Byte-lane expectations follow DMEM_BYTE_SEL_EN as seen by the compile.

module tb_data_mem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_ready, rsp_valid;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_sel;
  logic        z_req_valid, z_req_we, z_req_ready, z_rsp_valid;
  logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
  logic [3:0]  z_req_sel;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_mem_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_sel_i   (req_sel),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata)
  );

  data_mem_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_dut_z (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (z_req_valid),
    .req_ready_o (z_req_ready),
    .req_we_i    (z_req_we),
    .req_addr_i  (z_req_addr),
    .req_sel_i   (z_req_sel),
    .req_wdata_i (z_req_wdata),
    .rsp_valid_o (z_rsp_valid),
    .rsp_rdata_o (z_rsp_rdata)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit z, input logic v, input logic we, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] wd);
    if (z) begin
      z_req_valid = v; z_req_we = we; z_req_addr = a; z_req_sel = s; z_req_wdata = wd;
    end else begin
      req_valid = v; req_we = we; req_addr = a; req_sel = s; req_wdata = wd;
    end
  endtask

  // Issues one request from an idle cycle and returns in the idle cycle after RESP.
  task automatic xact(input bit z, input logic we, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] wd, output logic [31:0] rd);
    bit seen = 1'b0;
    rd = 32'hxxxx_xxxx;
    drive(z, 1'b1, we, a, s, wd);
    tick;
    drive(z, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    for (int i = 0; i < 20 && !seen; i++) begin
      if (z ? z_rsp_valid : rsp_valid) begin
        seen = 1'b1;
        rd   = z ? z_rsp_rdata : rsp_rdata;
      end
      tick;
    end
    if (!seen) begin
      n_vec++;
      n_fail++;
      $display("FAIL xact_timeout addr=%h: got no rsp_valid, want pulse within 20 cycles", a);
    end
  endtask

  task automatic test_reset;
    #1;
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_ready: got %b want 1", req_ready);
    end
    n_vec++;
    if (rsp_valid !== 1'b0 || z_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_valid: got %b/%b want 0/0", rsp_valid, z_rsp_valid);
    end
    n_vec++;
    if (rsp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL rst_rdata: got %h want 00000000", rsp_rdata);
    end
    tick;
    tick;
    rst = 1'b0;
    tick;
    n_vec++;
    if (req_ready !== 1'b1 || z_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL post_rst_ready: got %b/%b want 1/1", req_ready, z_req_ready);
    end
  endtask

  task automatic test_store_load;
    logic [31:0] rd;
    drive(1'b0, 1'b1, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL st_ready_c0: got %b want 1", req_ready);
    end
    tick;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    for (int c = 1; c <= 3; c++) begin
      n_vec++;
      if (rsp_valid !== (c == 3) || req_ready !== 1'b0 || rsp_rdata !== 32'h0) begin
        n_fail++;
        $display("FAIL st_cycle%0d: got valid=%b ready=%b rdata=%h want valid=%b ready=0 rdata=0",
                 c, rsp_valid, req_ready, rsp_rdata, (c == 3));
      end
      tick;
    end
    n_vec++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL st_cycle4: got valid=%b ready=%b want 0/1", rsp_valid, req_ready);
    end
    xact(1'b0, 1'b0, 32'h10, 4'hF, 32'h0, rd);
    n_vec++;
    if (rd !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL ld_0x10: got %h want deadbeef", rd);
    end
    tick;
    n_vec++;
    if (rsp_rdata !== 32'hDEAD_BEEF || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rdata_hold: got %h valid=%b want deadbeef valid=0", rsp_rdata, rsp_valid);
    end
  endtask

  task automatic test_byte_sel;
    logic [31:0] rd;
    logic [31:0] exp;
`ifdef DMEM_BYTE_SEL_EN
    exp = 32'hDEAD_ABEF;
`else
    exp = 32'h0000_AB00;
`endif
    xact(1'b0, 1'b1, 32'h10, 4'b0010, 32'h0000_AB00, rd);
    n_vec++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL st_rsp_rdata: got %h want 00000000", rd);
    end
    xact(1'b0, 1'b0, 32'h10, 4'hF, 32'h0, rd);
    n_vec++;
    if (rd !== exp) begin
      n_fail++; $display("FAIL byte_sel_ld: got %h want %h", rd, exp);
    end
  endtask

  task automatic test_alias;
    logic [31:0] rd;
    xact(1'b0, 1'b1, 32'h1010, 4'hF, 32'h1234_5678, rd);
    xact(1'b0, 1'b0, 32'h10, 4'hF, 32'h0, rd);
    n_vec++;
    if (rd !== 32'h1234_5678) begin
      n_fail++; $display("FAIL alias_ld_0x10: got %h want 12345678", rd);
    end
    xact(1'b0, 1'b0, 32'h2013, 4'h1, 32'h0, rd);
    n_vec++;
    if (rd !== 32'h1234_5678) begin
      n_fail++; $display("FAIL alias_ld_0x2013: got %h want 12345678", rd);
    end
  endtask

  task automatic test_reset_in_wait;
    logic [31:0] rd;
    bit pulsed = 1'b0;
    xact(1'b0, 1'b1, 32'h20, 4'hF, 32'h1111_1111, rd);
    xact(1'b0, 1'b0, 32'h20, 4'hF, 32'h0, rd);
    n_vec++;
    if (rd !== 32'h1111_1111) begin
      n_fail++; $display("FAIL pre_rst_ld: got %h want 11111111", rd);
    end
    drive(1'b0, 1'b1, 1'b1, 32'h20, 4'hF, 32'hCAFE_F00D);
    tick;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    tick;
    rst = 1'b1;
    #1;
    n_vec++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_rst: got valid=%b rdata=%h ready=%b want 0/00000000/1",
               rsp_valid, rsp_rdata, req_ready);
    end
    for (int i = 0; i < 2; i++) begin
      tick;
      if (rsp_valid) pulsed = 1'b1;
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (rsp_valid) pulsed = 1'b1;
    end
    n_vec++;
    if (pulsed || req_ready !== 1'b1 || rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_discard: got pulsed=%b ready=%b rdata=%h want 0/1/00000000",
               pulsed, req_ready, rsp_rdata);
    end
    xact(1'b0, 1'b0, 32'h20, 4'hF, 32'h0, rd);
    n_vec++;
    if (rd !== 32'h1111_1111) begin
      n_fail++; $display("FAIL post_rst_ld: got %h want 11111111", rd);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd;
    drive(1'b1, 1'b1, 1'b1, 32'h8, 4'hF, 32'hA5A5_0F0F);
    for (int c = 0; c <= 4; c++) begin
      if (c == 3) begin
        n_vec++;
        if (z_rsp_valid !== 1'b1) begin
          n_fail++; $display("FAIL b2b_c3_valid: got %b want 1", z_rsp_valid);
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      end else begin
        n_vec++;
        if (z_rsp_valid !== (c == 1) || z_req_ready !== (c != 1)) begin
          n_fail++;
          $display("FAIL b2b_c%0d: got valid=%b ready=%b want valid=%b ready=%b",
                   c, z_rsp_valid, z_req_ready, (c == 1), (c != 1));
        end
      end
      tick;
    end
    xact(1'b1, 1'b0, 32'h8, 4'hF, 32'h0, rd);
    n_vec++;
    if (rd !== 32'hA5A5_0F0F) begin
      n_fail++; $display("FAIL b2b_ld: got %h want a5a50f0f", rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    test_reset;
    test_store_load;
    test_byte_sel;
    test_alias;
    test_reset_in_wait;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
